shift_reg_universal: RTL and testbench

Parametrised universal shift register for the serial/parallel datapath family. It supports parallel load, logical, arithmetic and rotate shifts in both directions, with serial input and output. A single-step mode applies one operation per cycle. A burst mode shifts a latched operation a programmed number of times and reports completion with a busy/done handshake.

---
 rtl/shift_reg_pkg.sv | 26 ++
 rtl/shift_step.sv | 47 ++++
 rtl/shift_reg_universal.sv | 99 +++++++++
 tb/tb_shift_reg_universal.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register family: operation codes,
// burst FSM states and a helper that classifies shift/rotate opcodes.
// No ports; imported by shift_step and shift_reg_universal.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SRA  = 3'd4,
    OP_ROR  = 3'd5,
    OP_ROL  = 3'd6
  } shift_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } shift_state_e;

  // True for the codes that move bits (SHR..ROL); HOLD, LOAD and 7 are not.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= 3'd2) && (op <= 3'd6);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step shared by the single-step and burst paths.
// Ports: cur (current value), op, ser_in (fill bit) -> nxt (shifted value), out_bit (expelled bit).
// Non-shift codes pass cur through unchanged and report out_bit=0.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] nxt,
  output logic             out_bit
);

  always_comb begin
    nxt     = cur;
    out_bit = 1'b0;
    case (shift_op_e'(op))
      OP_SHR: begin
        nxt     = {ser_in, cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      OP_SHL: begin
        nxt     = {cur[WIDTH-2:0], ser_in};
        out_bit = cur[WIDTH-1];
      end
      OP_SRA: begin
        nxt     = {cur[WIDTH-1], cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      OP_ROR: begin
        nxt     = {cur[0], cur[WIDTH-1:1]};
        out_bit = cur[0];
      end
      OP_ROL: begin
        nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
        out_bit = cur[WIDTH-1];
      end
      default: begin
        nxt     = cur;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: parallel load, logical/arithmetic/rotate shifts, and
// counted bursts with a busy/done handshake. All outputs registered.
// Ports: clk, rst (async, active-high), op, data_in, ser_in, start, count ->
//        data_out, ser_out, busy, done.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] ONE = CW'(1);

  shift_state_e     state_q;
  shift_op_e        op_q;
  logic [CW-1:0]    remaining_q;
  logic [WIDTH-1:0] data_q;
  logic             ser_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_nxt;
  logic             step_bit;

  // During a burst the latched op drives the step; live op is ignored.
  assign step_op = (state_q == ST_BUSY) ? op_q : op;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .cur     (data_q),
    .op      (step_op),
    .ser_in  (ser_in),
    .nxt     (step_nxt),
    .out_bit (step_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_HOLD;
      remaining_q <= '0;
      data_q      <= '0;
      ser_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && is_shift_op(op)) begin
            // Launch edge only latches the burst; no shift happens here.
            if (count != '0) begin
              state_q     <= ST_BUSY;
              busy_q      <= 1'b1;
              op_q        <= shift_op_e'(op);
              remaining_q <= count;
            end else begin
              done_q <= 1'b1;
            end
          end else if (op == OP_LOAD) begin
            data_q <= data_in;
          end else if (is_shift_op(op)) begin
            data_q <= step_nxt;
            ser_q  <= step_bit;
          end
        end
        ST_BUSY: begin
          data_q      <= step_nxt;
          ser_q       <= step_bit;
          remaining_q <= remaining_q - ONE;
          if (remaining_q == ONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out = data_q;
  assign ser_out  = ser_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic [7:0] data_in;
  logic       ser_in;
  logic       start;
  logic [3:0] count;
  logic [7:0] data_out;
  logic       ser_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference model state (integer arithmetic on the architectural view)
  int m_data, m_ser, m_busy, m_done, m_rem, m_op;

  shift_reg_universal #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .data_in  (data_in),
    .ser_in   (ser_in),
    .start    (start),
    .count    (count),
    .data_out (data_out),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] din;
    logic       ser;
    logic       st;
    logic [3:0] cnt;
    logic [7:0] e_data;
    logic       e_ser;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mshift(input int o, input int v, input int s,
                                 output int nv, output int ob);
    nv = v;
    ob = 0;
    case (o)
      2: begin nv = v / 2 + s * 128;            ob = v % 2;   end
      3: begin nv = (v * 2) % 256 + s;          ob = v / 128; end
      4: begin nv = v / 2 + (v / 128) * 128;    ob = v % 2;   end
      5: begin nv = v / 2 + (v % 2) * 128;      ob = v % 2;   end
      6: begin nv = (v * 2) % 256 + v / 128;    ob = v / 128; end
      default: begin nv = v; ob = 0; end
    endcase
  endfunction

  function automatic void model_reset();
    m_data = 0; m_ser = 0; m_busy = 0; m_done = 0; m_rem = 0; m_op = 0;
  endfunction

  function automatic void model_step(input int o, input int d, input int s,
                                     input int st, input int c);
    int nv, ob;
    if (m_busy != 0) begin
      mshift(m_op, m_data, s, nv, ob);
      m_data = nv;
      m_ser  = ob;
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0) ? 1 : 0;
      if (m_rem == 0) m_busy = 0;
    end else begin
      m_done = 0;
      if (st != 0 && o >= 2 && o <= 6) begin
        if (c == 0) m_done = 1;
        else begin
          m_busy = 1;
          m_rem  = c;
          m_op   = o;
        end
      end else if (o == 1) begin
        m_data = d;
      end else if (o >= 2 && o <= 6) begin
        mshift(o, m_data, s, nv, ob);
        m_data = nv;
        m_ser  = ob;
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model, then compare just after the edge.
  task automatic cyc(input logic [2:0] o, input logic [7:0] d, input logic s,
                     input logic st, input logic [3:0] c);
    op = o; data_in = d; ser_in = s; start = st; count = c;
    model_step(int'(o), int'(d), int'(s), int'(st), int'(c));
    @(posedge clk);
    #1;
    chk("model_data", int'(data_out), m_data);
    chk("model_ser",  int'(ser_out),  m_ser);
    chk("model_busy", int'(busy),     m_busy);
    chk("model_done", int'(done),     m_done);
    if (busy && done) chk("busy_and_done", 1, 0);
  endtask

  task automatic hold_cyc();
    cyc(3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
  endtask

  // Run HOLD cycles until done is seen or the budget runs out.
  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      hold_cyc();
      n++;
    end
    chk(name, int'(done), 1);
  endtask

  initial begin
    rst = 1'b1; op = 3'd0; data_in = 8'h00; ser_in = 1'b0; start = 1'b0; count = 4'd0;
    model_reset();
    #12;
    chk("reset_data", int'(data_out), 0);
    chk("reset_ser",  int'(ser_out),  0);
    chk("reset_busy", int'(busy),     0);
    chk("reset_done", int'(done),     0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset lands between edges
    cyc(3'd1, 8'hB4, 1'b0, 1'b0, 4'd0);
    chk("load_b4", int'(data_out), 8'hB4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data", int'(data_out), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    tbl[0]  = '{3'd1, 8'hB4, 1'b0, 1'b0, 4'd0, 8'hB4, 1'b0, 1'b0, 1'b0}; // LOAD
    tbl[1]  = '{3'd2, 8'h00, 1'b1, 1'b0, 4'd0, 8'hDA, 1'b0, 1'b0, 1'b0}; // SHR ser=1
    tbl[2]  = '{3'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'hB4, 1'b1, 1'b0, 1'b0}; // SHL ser=0
    tbl[3]  = '{3'd4, 8'h00, 1'b0, 1'b0, 4'd0, 8'hDA, 1'b0, 1'b0, 1'b0}; // SRA
    tbl[4]  = '{3'd0, 8'hFF, 1'b1, 1'b0, 4'd0, 8'hDA, 1'b0, 1'b0, 1'b0}; // HOLD
    tbl[5]  = '{3'd7, 8'hFF, 1'b1, 1'b0, 4'd0, 8'hDA, 1'b0, 1'b0, 1'b0}; // reserved
    tbl[6]  = '{3'd1, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0}; // LOAD
    tbl[7]  = '{3'd6, 8'h00, 1'b0, 1'b0, 4'd0, 8'h03, 1'b1, 1'b0, 1'b0}; // ROL
    tbl[8]  = '{3'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0}; // ROR
    tbl[9]  = '{3'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0}; // ROR
    tbl[10] = '{3'd1, 8'h3C, 1'b0, 1'b1, 4'd3, 8'h3C, 1'b1, 1'b0, 1'b0}; // start+LOAD
    tbl[11] = '{3'd2, 8'h00, 1'b1, 1'b1, 4'd0, 8'h3C, 1'b1, 1'b0, 1'b1}; // count=0
    tbl[12] = '{3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h3C, 1'b1, 1'b0, 1'b0}; // HOLD

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].op, tbl[i].din, tbl[i].ser, tbl[i].st, tbl[i].cnt);
      chk($sformatf("vec%0d_data", i), int'(data_out), int'(tbl[i].e_data));
      chk($sformatf("vec%0d_ser", i),  int'(ser_out),  int'(tbl[i].e_ser));
      chk($sformatf("vec%0d_busy", i), int'(busy),     int'(tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done),     int'(tbl[i].e_done));
    end

    // SRA burst of 3 from 0x80, with LOAD attempts ignored while busy
    cyc(3'd1, 8'h80, 1'b0, 1'b0, 4'd0);
    cyc(3'd4, 8'h00, 1'b0, 1'b1, 4'd3);
    chk("sra_launch_busy", int'(busy), 1);
    chk("sra_launch_data", int'(data_out), 8'h80);
    cyc(3'd1, 8'h11, 1'b1, 1'b1, 4'd7);
    chk("sra_s1", int'(data_out), 8'hC0);
    cyc(3'd1, 8'h11, 1'b1, 1'b0, 4'd0);
    chk("sra_s2", int'(data_out), 8'hE0);
    cyc(3'd1, 8'h11, 1'b0, 1'b0, 4'd0);
    chk("sra_s3", int'(data_out), 8'hF0);
    chk("sra_done", int'(done), 1);
    chk("sra_busy_clr", int'(busy), 0);
    hold_cyc();
    chk("sra_done_pulse", int'(done), 0);

    // Rotate bursts of WIDTH and WIDTH+1, back-to-back after the done cycle
    cyc(3'd1, 8'h5A, 1'b0, 1'b0, 4'd0);
    cyc(3'd5, 8'h00, 1'b0, 1'b1, 4'd8);
    wait_done("ror8_done", 20);
    chk("ror8_data", int'(data_out), 8'h5A);
    cyc(3'd5, 8'h00, 1'b0, 1'b1, 4'd9);
    chk("ror9_busy", int'(busy), 1);
    wait_done("ror9_done", 20);
    chk("ror9_data", int'(data_out), 8'h2D);

    // Reset in the middle of an SHL burst
    cyc(3'd1, 8'hFF, 1'b0, 1'b0, 4'd0);
    cyc(3'd3, 8'h00, 1'b0, 1'b1, 4'd5);
    hold_cyc();
    hold_cyc();
    chk("shl_two", int'(data_out), 8'hFC);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midburst_rst_data", int'(data_out), 0);
    chk("midburst_rst_ser",  int'(ser_out),  0);
    chk("midburst_rst_busy", int'(busy),     0);
    chk("midburst_rst_done", int'(done),     0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    hold_cyc();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done", int'(done), 0);
    chk("post_rst_data", int'(data_out), 0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      cyc(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
